// File: rtl/uart_rx.sv
// UART receiver: oversamples RX_IN by a runtime prescale, majority-votes three mid-bit samples
// and recovers start / data / optional parity / stop, reporting a valid frame or an error pulse.
module uart_rx #(
   parameter int DATA_WD     = 8,
   parameter int PRESCALE_WD = 6
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   RX_IN,
   input  logic [PRESCALE_WD-1:0] prescale,
   input  logic                   parity_enable,
   input  logic                   parity_type,
   output logic [DATA_WD-1:0]     P_DATA,
   output logic                   data_valid,
   output logic                   parity_error,
   output logic                   stop_error
);

   localparam int BIT_CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                 state_q;
   logic [PRESCALE_WD-1:0] edge_cnt_q, edge_cnt_d;
   logic [PRESCALE_WD-1:0] prescale_q;
   logic [BIT_CNT_WD-1:0]  bit_cnt_q;
   logic                   parity_enable_q, parity_type_q, parity_err_q;
   logic [2:0]             samples_q;
   logic [DATA_WD-1:0]     shift_q, shift_d, p_data_q;
   logic                   data_valid_q, parity_error_q, stop_error_q;

   logic [PRESCALE_WD-1:0] mid, last;
   logic                   bit_end, bit_val, parity_exp;

   always_comb begin
      mid        = prescale_q >> 1;
      last       = prescale_q - PRESCALE_WD'(1);
      bit_end    = (edge_cnt_q == last);
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_WD'(1);
      bit_val    = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                   (samples_q[1] & samples_q[2]);
      shift_d    = {bit_val, shift_q[DATA_WD-1:1]};
      parity_exp = parity_type_q ? ~^shift_q : ^shift_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q         <= S_IDLE;
         edge_cnt_q      <= '0;
         bit_cnt_q       <= '0;
         prescale_q      <= '0;
         parity_enable_q <= 1'b0;
         parity_type_q   <= 1'b0;
         parity_err_q    <= 1'b0;
         samples_q       <= '0;
         shift_q         <= '0;
         p_data_q        <= '0;
         data_valid_q    <= 1'b0;
         parity_error_q  <= 1'b0;
         stop_error_q    <= 1'b0;
      end else begin
         data_valid_q   <= 1'b0;
         parity_error_q <= 1'b0;
         stop_error_q   <= 1'b0;
         if (state_q == S_IDLE) begin
            // The cycle that sees the falling edge is edge 0 of the start bit.
            if (!RX_IN) begin
               state_q         <= S_START;
               edge_cnt_q      <= PRESCALE_WD'(1);
               bit_cnt_q       <= '0;
               prescale_q      <= prescale;
               parity_enable_q <= parity_enable;
               parity_type_q   <= parity_type;
               parity_err_q    <= 1'b0;
            end
         end else begin
            edge_cnt_q <= edge_cnt_d;
            if (edge_cnt_q == mid - PRESCALE_WD'(1)) samples_q[0] <= RX_IN;
            if (edge_cnt_q == mid)                   samples_q[1] <= RX_IN;
            if (edge_cnt_q == mid + PRESCALE_WD'(1)) samples_q[2] <= RX_IN;
            if (bit_end) begin
               case (state_q)
                  S_START: begin
                     if (bit_val) begin
                        state_q <= S_IDLE;
                     end else begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                     end
                  end
                  S_DATA: begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_q + BIT_CNT_WD'(1);
                     if (bit_cnt_q == BIT_CNT_WD'(DATA_WD - 1))
                        state_q <= parity_enable_q ? S_PARITY : S_STOP;
                  end
                  S_PARITY: begin
                     parity_err_q <= (bit_val != parity_exp);
                     state_q      <= S_STOP;
                  end
                  S_STOP: begin
                     state_q <= S_IDLE;
                     if (!bit_val) begin
                        stop_error_q <= 1'b1;
                     end else if (parity_err_q) begin
                        parity_error_q <= 1'b1;
                     end else begin
                        p_data_q     <= shift_q;
                        data_valid_q <= 1'b1;
                     end
                  end
                  default: state_q <= S_IDLE;
               endcase
            end
         end
      end
   end

   assign P_DATA       = p_data_q;
   assign data_valid   = data_valid_q;
   assign parity_error = parity_error_q;
   assign stop_error   = stop_error_q;

endmodule
